// File: rtl/stream_rr_arbiter_pkg.sv
// Shared constants and helpers for the stream round-robin arbiter slice.
package stream_rr_arbiter_pkg;

  // Index width for a vector of 'value' entries; never narrower than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_enc.sv
// One-hot to binary encoder with optional one-hot validity check.
module bits_encoder
  import stream_rr_arbiter_pkg::*;
#(
  parameter int BITS                = 4,
  parameter bit INVALID_VALUE_CHECK = 1,
  localparam int OW                 = clog2(BITS)
) (
  input  logic [BITS-1:0] in,
  output logic [OW-1:0]   out,
  output logic            out_valid
);

  // Each output bit is the OR of the inputs whose index has that bit set.
  for (genvar gi = 0; gi < OW; gi++) begin : g_bit
    logic [BITS-1:0] mask;
    always_comb begin
      mask = '0;
      for (int i = 0; i < BITS; i++) begin
        mask[i] = ((i >> gi) & 1) == 1;
      end
    end
    assign out[gi] = |(in & mask);
  end

  assign out_valid = INVALID_VALUE_CHECK ? $onehot(in) : |in;

endmodule

// File: rtl/stream_rr_arbiter_pick.sv
// Combinational round-robin pick: first set request at or after ptr, one-hot.
module rr_priority_pick #(
  parameter int CHANNELS = 4,
  parameter int W        = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [W-1:0]        ptr,
  output logic [CHANNELS-1:0] winner
);

  logic [CHANNELS-1:0] rot;
  logic [CHANNELS-1:0] rot_win;

  // Rotate so ptr lands on bit 0, take the lowest set bit, rotate back.
  assign rot     = CHANNELS'({req, req} >> ptr);
  assign rot_win = rot & (~rot + CHANNELS'(1));
  assign winner  = CHANNELS'(({rot_win, rot_win} << ptr) >> CHANNELS);

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter for stream sources; holds a registered one-hot grant per packet.
module stream_rr_arbiter
  import stream_rr_arbiter_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter bit LOCK_ON_PACKET = 1,
  localparam int W             = clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] req,
  input  logic [CHANNELS-1:0] req_last,
  input  logic                link_ready,
  output logic [CHANNELS-1:0] grant,
  output logic                grant_valid,
  output logic [W-1:0]        grant_idx,
  output logic                drop_err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]          state;
  logic [W-1:0]        ptr;
  logic [CHANNELS-1:0] grant_r;
  logic                drop_r;
  logic                enc_valid;
  logic                req_g;
  logic                last_g;
  logic                xfer;
  logic                release_now;
  logic                abort_now;
  logic [W-1:0]        ptr_adv;
  logic [W-1:0]        pick_ptr;
  logic [CHANNELS-1:0] winner;

  bits_encoder #(
    .BITS                (CHANNELS),
    .INVALID_VALUE_CHECK (1)
  ) u_enc (
    .in        (grant_r),
    .out       (grant_idx),
    .out_valid (enc_valid)
  );

  assign grant       = grant_r;
  assign grant_valid = (state == LOCKED);
  assign drop_err    = drop_r;

  assign req_g       = |(req & grant_r);
  assign last_g      = |(req_last & grant_r);
  assign xfer        = grant_valid & link_ready & req_g;
  assign release_now = xfer & (last_g | !LOCK_ON_PACKET);
  assign abort_now   = grant_valid & !req_g;

  // The channel just served moves to lowest priority before re-arbitration.
  assign ptr_adv  = (grant_idx == W'(CHANNELS - 1)) ? '0 : grant_idx + W'(1);
  assign pick_ptr = (release_now | abort_now) ? ptr_adv : ptr;

  rr_priority_pick #(
    .CHANNELS (CHANNELS),
    .W        (W)
  ) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .winner (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      grant_r <= '0;
      drop_r  <= 1'b0;
    end else begin
      drop_r <= abort_now;
      case (state)
        IDLE: begin
          if (|req) begin
            grant_r <= winner;
            state   <= LOCKED;
          end
        end
        default: begin
          if (release_now | abort_now) begin
            ptr     <= ptr_adv;
            grant_r <= winner;
            state   <= (|req) ? LOCKED : IDLE;
          end
        end
      endcase
    end
  end

  a_enc_valid : assert property (@(posedge clk) disable iff (!rst_n) enc_valid == grant_valid);
  a_onehot0   : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_r));

endmodule
